// File: rtl/ndata_width_narrower.sv
// ndata_width_narrower
//
// Splits a wide element stream into a narrower one. Each accepted wide beat
// is captured in a one-beat buffer and replayed as NUM_SLOTS narrow beats,
// lowest slot first. On a last beat, trailing slots whose keep bits are all
// zero are not emitted. A last beat with no keep bits set still produces one
// narrow beat (keep=0, last=1), so the packet boundary survives.
// When both widths are equal the block is a plain wire-through with no state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    IN_WIDTH elements of data_t, element 0 in the lowest position
//   in_keep    per-element keep for the wide beat
//   in_last    wide beat closes a packet
//   in_valid   wide beat present
//   in_ready   block can take the wide beat this cycle
//   out_data   OUT_WIDTH elements of the current narrow slot
//   out_keep   keep bits of the current narrow slot
//   out_last   narrow beat closes the packet
//   out_valid  narrow beat present
//   out_ready  downstream takes the narrow beat this cycle

module ndata_width_narrower #(
    parameter type data_t    = logic [7:0],
    parameter int  IN_WIDTH  = 8,
    parameter int  OUT_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,

    input  data_t [IN_WIDTH-1:0]       in_data,
    input  logic  [IN_WIDTH-1:0]       in_keep,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,

    output data_t [OUT_WIDTH-1:0]      out_data,
    output logic  [OUT_WIDTH-1:0]      out_keep,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int NUM_SLOTS = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // Reject configurations the slicing logic cannot handle.
    if ((IN_WIDTH <= 0) || ((IN_WIDTH & (IN_WIDTH - 1)) != 0)) begin : g_bad_in_width
        $error("ndata_width_narrower: IN_WIDTH must be a power of two");
    end
    if ((OUT_WIDTH <= 0) || ((OUT_WIDTH & (OUT_WIDTH - 1)) != 0)) begin : g_bad_out_width
        $error("ndata_width_narrower: OUT_WIDTH must be a power of two");
    end
    if (OUT_WIDTH > IN_WIDTH) begin : g_bad_ratio
        $error("ndata_width_narrower: OUT_WIDTH must not exceed IN_WIDTH");
    end
    if ((OUT_WIDTH > 0) && ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_multiple
        $error("ndata_width_narrower: IN_WIDTH must be a multiple of OUT_WIDTH");
    end

    if (IN_WIDTH == OUT_WIDTH) begin : g_passthrough

        assign out_data  = in_data;
        assign out_keep  = in_keep;
        assign out_last  = in_last;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;

    end else begin : g_narrow

        typedef enum logic {
            EMPTY = 1'b0,
            HOLD  = 1'b1
        } state_t;

        state_t                 state_q;
        state_t                 state_d;

        data_t [IN_WIDTH-1:0]   buf_data;
        logic  [IN_WIDTH-1:0]   buf_keep;
        logic                   buf_last;
        logic  [IDX_W-1:0]      slot_idx;
        logic  [IDX_W-1:0]      final_idx;

        logic                   held;
        logic                   at_final;
        logic                   accept;
        logic  [IDX_W-1:0]      last_keep_slot;
        logic  [IDX_W-1:0]      load_final;

        assign held     = (state_q == HOLD);
        assign at_final = (slot_idx == final_idx);

        // The buffer frees up in the same cycle its final slot is handed off,
        // which is what lets back-to-back wide beats stream without a bubble.
        assign in_ready = !held || (out_ready && at_final);
        assign accept   = in_valid && in_ready;

        // Highest slot with any keep bit set; stays 0 when nothing is kept so
        // an empty last beat still emits a single boundary beat.
        always_comb begin
            last_keep_slot = '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (|in_keep[s*OUT_WIDTH +: OUT_WIDTH]) begin
                    last_keep_slot = IDX_W'(s);
                end
            end
        end

        assign load_final = in_last ? last_keep_slot : IDX_W'(NUM_SLOTS - 1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // EMPTY waits for a wide beat; HOLD returns to EMPTY only when the
        // final slot leaves and no follow-on beat is waiting.
        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready && at_final && !in_valid) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Buffer load on accept; otherwise walk the slot index on each
        // narrow handshake until the final slot.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                buf_data  <= '0;
                buf_keep  <= '0;
                buf_last  <= 1'b0;
                slot_idx  <= '0;
                final_idx <= '0;
            end else if (accept) begin
                buf_data  <= in_data;
                buf_keep  <= in_keep;
                buf_last  <= in_last;
                slot_idx  <= '0;
                final_idx <= load_final;
            end else if (held && out_ready && !at_final) begin
                slot_idx  <= slot_idx + 1'b1;
            end
        end

        assign out_valid = held;
        assign out_data  = buf_data[int'(slot_idx)*OUT_WIDTH +: OUT_WIDTH];
        assign out_keep  = buf_keep[int'(slot_idx)*OUT_WIDTH +: OUT_WIDTH];
        assign out_last  = buf_last && at_final;

    end

endmodule

// File: doc/ndata_width_narrower.md
Name: ndata_width_narrower

Overview:
Splits a wide ndata_i stream into a narrower ndata_i stream. It is the inverse neighbour of the widening converter, and sits downstream of wide processing stages to feed narrow sinks. Each wide input beat is held in a one-beat buffer and emitted as successive narrow slots, lowest slot first. On a last beat, trailing slots whose keep bits are all zero are dropped.

Parameters:
- data_t, (none, type), element type carried by both interfaces.
- IN_WIDTH, in.NUM_ELEMENTS (derived), elements per input beat; power of two.
- OUT_WIDTH, out.NUM_ELEMENTS (derived), elements per output beat; power of two, <= IN_WIDTH.
- NUM_SLOTS, IN_WIDTH/OUT_WIDTH (derived), narrow beats per wide beat.
- Elaboration assertions: both widths are powers of two; OUT_WIDTH <= IN_WIDTH; IN_WIDTH % OUT_WIDTH == 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in  ndata_i.s  data[IN_WIDTH] of data_t, keep[IN_WIDTH], last, valid, ready  wide input stream.
- out  ndata_i.m  data[OUT_WIDTH] of data_t, keep[OUT_WIDTH], last, valid, ready  narrow output stream.

Behaviour:
- IN_WIDTH == OUT_WIDTH: pure combinational pass-through of data, keep, last, valid and ready. No state.
- Registers:
  - held flag
  - beat buffer (data, keep, last)
  - slot_idx, $clog2(NUM_SLOTS) bits
  - final_idx, $clog2(NUM_SLOTS) bits
- States: EMPTY (held=0) and HOLD (held=1).
- Reset, asynchronous: held=0, slot_idx=0, final_idx=0, buffer cleared. Outputs at reset: out.valid=0, out.last=0, out.keep=0, out.data=0. If reset hits mid-beat, the partially emitted beat is discarded. After release the block is EMPTY and in.ready=1.
- in.ready = !held || (out.ready && slot_idx == final_idx).
  - Combinational from registers plus out.ready.
  - No dependency on in.valid.
- Accept occurs when in.valid && in.ready. On accept:
  - Load the buffer, set held=1, slot_idx=0.
  - final_idx = NUM_SLOTS-1 if in.last=0.
  - If in.last=1, final_idx = highest slot index whose OUT_WIDTH keep bits contain any 1. If in.keep is all zero, final_idx=0.
- Output is driven from registers only:
  - out.valid = held
  - out.data = buffer.data[slot_idx*OUT_WIDTH +: OUT_WIDTH]
  - out.keep = buffer.keep, same slice
  - out.last = buffer.last && slot_idx == final_idx
- Non-last beats emit every slot, including slots with all-zero keep. keep is passed through unchanged.
- On an output handshake (held && out.ready):
  - slot_idx != final_idx: slot_idx increments.
  - slot_idx == final_idx: the beat completes. If in.valid in the same cycle, the next beat is accepted (slot_idx=0, stays HOLD). Otherwise held=0.
- Latency: the first slot is valid one cycle after accept. Continuous traffic has no bubble between wide beats.
- Throughput: one wide beat per NUM_SLOTS cycles; fewer cycles for truncated last beats.
- Backpressure: while out.ready=0, all out signals are held stable and slot_idx does not change. AXI-style: out.valid never drops without a handshake except on reset.
- A zero-keep last beat produces exactly one output beat with keep=0 and last=1, so the packet boundary is preserved.

Test Plan:
Configuration: IN_WIDTH=8, OUT_WIDTH=2, 8-bit data_t, element i = i.
1. One beat, keep=0xFF, last=0, out.ready=1 -> 4 out beats with data {0,1},{2,3},{4,5},{6,7}, keep=2'b11, last=0. in.ready low for 3 cycles and high on the 4th.
2. Beat with keep=0x07, last=1 -> 2 out beats: {0,1} keep=11 last=0, then {2,3} keep=01 last=1. A second valid beat presented is accepted in the same cycle as the final slot's handshake.
3. Beat with keep=0x00, last=1 -> exactly one out beat: data {0,1}, keep=00, last=1.
4. Hold out.ready=0 for 5 cycles at slot 1 -> out.data stays {2,3}, out.valid=1, in.ready=0. Resume -> slots 2 and 3 follow with no loss or duplication.
5. Two back-to-back full beats with out.ready=1 continuously -> 8 consecutive out.valid cycles with no bubble, data in order.
6. Assert rst while at slot 2 -> out.valid=0 and out.last=0 immediately, without waiting for a clock edge. After release in.ready=1, and the next beat starts at slot 0.
